fighter_fsm: RTL and testbench

Per-player fighter controller that runs the animation/action state machine and horizontal position for one fighter. It sits directly upstream of the sprite ROM renderer, driving that renderer's currentstate (sprite select), posx and posy inputs. It also flags the active hitbox window. The top level instantiates it twice: player 1 with FACING_RIGHT=1 and player 2 with FACING_RIGHT=0. All decisions advance only on frame_tick, one pulse per video frame.

---
 rtl/fighter_fsm.sv | 181 ++++++++++++++++++
 tb/tb_fighter_fsm.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/fighter_fsm.sv
// Per-player fighter controller: action/animation state, horizontal position
// and hitbox/block flags, all advancing once per frame_tick.
module fighter_fsm #(
    parameter int START_X      = 100,
    parameter int GROUND_Y     = 300,
    parameter int MIN_X        = 0,
    parameter int MAX_X        = 527,
    parameter int FACING_RIGHT = 1,
    parameter int FWD_STEP     = 3,
    parameter int BACK_STEP    = 2,
    parameter int KNOCKBACK    = 8,
    parameter int ATK_START_N  = 5,
    parameter int ATK_END_N    = 2,
    parameter int ATK_PULL_N   = 16,
    parameter int DIR_START_N  = 4,
    parameter int DIR_END_N    = 3,
    parameter int DIR_PULL_N   = 15,
    parameter int HITSTUN_N    = 15,
    parameter int BLOCK_N      = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       btn_fwd,
    input  logic       btn_back,
    input  logic       btn_attack,
    input  logic       btn_dir,
    input  logic       hit_in,
    output logic [3:0] currentstate,
    output logic [9:0] posx,
    output logic [9:0] posy,
    output logic       attack_active,
    output logic       blocking
);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_WALK     = 4'd1,
        S_WALKBACK = 4'd2,
        S_ATKSTART = 4'd3,
        S_ATKEND   = 4'd4,
        S_ATKPULL  = 4'd5,
        S_DIRSTART = 4'd6,
        S_DIREND   = 4'd7,
        S_DIRPULL  = 4'd8,
        S_GOTHIT   = 4'd9,
        S_BLOCK    = 4'd10
    } state_t;

    localparam int SIGN = (FACING_RIGHT != 0) ? 1 : -1;
    localparam logic signed [10:0] FWD_DELTA  = 11'(SIGN * FWD_STEP);
    localparam logic signed [10:0] BACK_DELTA = 11'(-SIGN * BACK_STEP);
    localparam logic signed [10:0] KB_DELTA   = 11'(-SIGN * KNOCKBACK);
    localparam logic signed [10:0] MIN_S      = 11'(MIN_X);
    localparam logic signed [10:0] MAX_S      = 11'(MAX_X);

    state_t      state_q, state_d;
    logic [4:0]  timer_q, timer_d;
    logic [9:0]  posx_q, posx_d;
    logic        hit_pending_q, hit_pending_d;
    logic        atk_prev_q, atk_prev_d;
    logic        attack_active_q, attack_active_d;
    logic        blocking_q, blocking_d;

    logic               hit;
    logic               atk_edge;
    logic               expired;
    logic [4:0]         timer_dec;
    logic signed [10:0] delta;
    logic signed [10:0] sum;

    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q;
        hit_pending_d = hit_pending_q | hit_in;
        atk_prev_d    = atk_prev_q;
        delta         = '0;
        hit           = hit_pending_q | hit_in;
        atk_edge      = btn_attack & ~atk_prev_q;
        expired       = (timer_q == 5'd0);
        timer_dec     = timer_q - 5'd1;

        if (frame_tick) begin
            hit_pending_d = 1'b0;
            atk_prev_d    = btn_attack;
            if (hit && (state_q == S_WALKBACK || state_q == S_BLOCK)) begin
                state_d = S_BLOCK;
                timer_d = 5'(BLOCK_N - 1);
            end else if (hit && state_q != S_GOTHIT) begin
                state_d = S_GOTHIT;
                timer_d = 5'(HITSTUN_N - 1);
                delta   = KB_DELTA;
            end else begin
                unique case (state_q)
                    S_IDLE, S_WALK, S_WALKBACK: begin
                        timer_d = '0;
                        if (atk_edge && btn_dir) begin
                            state_d = S_DIRSTART;
                            timer_d = 5'(DIR_START_N - 1);
                        end else if (atk_edge) begin
                            state_d = S_ATKSTART;
                            timer_d = 5'(ATK_START_N - 1);
                        end else if (btn_fwd && !btn_back) begin
                            state_d = S_WALK;
                            delta   = FWD_DELTA;
                        end else if (btn_back && !btn_fwd) begin
                            state_d = S_WALKBACK;
                            delta   = BACK_DELTA;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                    S_ATKSTART: begin
                        state_d = expired ? S_ATKEND : state_q;
                        timer_d = expired ? 5'(ATK_END_N - 1) : timer_dec;
                    end
                    S_ATKEND: begin
                        state_d = expired ? S_ATKPULL : state_q;
                        timer_d = expired ? 5'(ATK_PULL_N - 1) : timer_dec;
                    end
                    S_DIRSTART: begin
                        state_d = expired ? S_DIREND : state_q;
                        timer_d = expired ? 5'(DIR_END_N - 1) : timer_dec;
                    end
                    S_DIREND: begin
                        state_d = expired ? S_DIRPULL : state_q;
                        timer_d = expired ? 5'(DIR_PULL_N - 1) : timer_dec;
                    end
                    S_ATKPULL, S_DIRPULL, S_GOTHIT, S_BLOCK: begin
                        state_d = expired ? S_IDLE : state_q;
                        timer_d = expired ? 5'd0 : timer_dec;
                    end
                    default: begin
                        state_d = S_IDLE;
                        timer_d = '0;
                    end
                endcase
            end
        end

        // Signed sum then clamp, so a step past either edge never wraps
        sum = $signed({1'b0, posx_q}) + delta;
        if (sum < MIN_S) begin
            posx_d = 10'(MIN_X);
        end else if (sum > MAX_S) begin
            posx_d = 10'(MAX_X);
        end else begin
            posx_d = sum[9:0];
        end

        attack_active_d = (state_d == S_ATKEND) || (state_d == S_DIREND);
        blocking_d      = (state_d == S_BLOCK);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_IDLE;
            timer_q         <= '0;
            posx_q          <= 10'(START_X);
            hit_pending_q   <= 1'b0;
            atk_prev_q      <= 1'b0;
            attack_active_q <= 1'b0;
            blocking_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            timer_q         <= timer_d;
            posx_q          <= posx_d;
            hit_pending_q   <= hit_pending_d;
            atk_prev_q      <= atk_prev_d;
            attack_active_q <= attack_active_d;
            blocking_q      <= blocking_d;
        end
    end

    assign currentstate  = state_q;
    assign posx          = posx_q;
    assign posy          = 10'(GROUND_Y);
    assign attack_active = attack_active_q;
    assign blocking      = blocking_q;

endmodule

// File: tb/tb_fighter_fsm.sv
// Scoreboard bench for fighter_fsm: each tick pushes its expected outputs,
// a monitor pops and compares on the cycle after every tick or reset.
module tb_fighter_fsm;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       frame_tick = 1'b0;
    logic       btn_fwd = 1'b0;
    logic       btn_back = 1'b0;
    logic       btn_attack = 1'b0;
    logic       btn_dir = 1'b0;
    logic       hit_in = 1'b0;
    logic [3:0] currentstate;
    logic [9:0] posx;
    logic [9:0] posy;
    logic       attack_active;
    logic       blocking;

    typedef struct {
        string      tag;
        logic [3:0] st;
        logic [9:0] x;
        logic       aa;
        logic       blk;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    logic tick_seen = 1'b0;

    always #5 clk = ~clk;

    fighter_fsm dut (
        .clk          (clk),
        .rst          (rst),
        .frame_tick   (frame_tick),
        .btn_fwd      (btn_fwd),
        .btn_back     (btn_back),
        .btn_attack   (btn_attack),
        .btn_dir      (btn_dir),
        .hit_in       (hit_in),
        .currentstate (currentstate),
        .posx         (posx),
        .posy         (posy),
        .attack_active(attack_active),
        .blocking     (blocking)
    );

    always @(posedge clk) tick_seen <= frame_tick | rst;

    always @(negedge clk) begin
        exp_t e;
        if (tick_seen) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_empty: output update with no expectation queued");
            end else begin
                e = sb.pop_front();
                if (currentstate !== e.st || posx !== e.x || posy !== 10'd300 ||
                    attack_active !== e.aa || blocking !== e.blk) begin
                    errors++;
                    $display("FAIL %s: got st=%0d x=%0d y=%0d aa=%b blk=%b, expected st=%0d x=%0d y=300 aa=%b blk=%b",
                             e.tag, currentstate, posx, posy, attack_active, blocking,
                             e.st, e.x, e.aa, e.blk);
                end
            end
        end
    end

    task automatic push(input string tag, input int st, input int x);
        exp_t e;
        e.tag = tag;
        e.st  = 4'(st);
        e.x   = 10'(x);
        e.aa  = (st == 4) || (st == 7);
        e.blk = (st == 10);
        sb.push_back(e);
    endtask

    task automatic tick(input string tag, input logic f, input logic b,
                        input logic a, input logic d, input logic h,
                        input int st, input int x);
        @(negedge clk);
        btn_fwd = f;
        btn_back = b;
        btn_attack = a;
        btn_dir = d;
        hit_in = h;
        frame_tick = 1'b1;
        push(tag, st, x);
        @(negedge clk);
        frame_tick = 1'b0;
        hit_in = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic hit_pulse();
        @(negedge clk);
        hit_in = 1'b1;
        @(negedge clk);
        hit_in = 1'b0;
    endtask

    task automatic reset_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rst = 1'b1;
            push("reset", 0, 100);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic reset_tick();
        @(negedge clk);
        rst = 1'b1;
        frame_tick = 1'b1;
        push("mid_reset", 0, 100);
        @(negedge clk);
        rst = 1'b0;
        frame_tick = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        repeat (60000) @(posedge clk);
        errors++;
        $display("FAIL watchdog: run exceeded cycle budget");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        int p;
        reset_cycles(2);

        for (int i = 0; i < 10; i++) tick("idle", 0, 0, 0, 0, 0, 0, 100);

        for (int k = 1; k <= 141; k++) tick("walk", 1, 0, 0, 0, 0, 1, 100 + 3 * k);
        tick("walk_526", 1, 0, 0, 0, 0, 1, 526);
        tick("walk_clamp", 1, 0, 0, 0, 0, 1, 527);
        tick("walk_hold", 1, 0, 0, 0, 0, 1, 527);
        tick("walk_release", 0, 0, 0, 0, 0, 0, 527);

        for (int i = 0; i < 5; i++) tick("atk_start", 0, 0, 1, 0, 0, 3, 527);
        for (int i = 0; i < 2; i++) tick("atk_end", 0, 0, 1, 0, 0, 4, 527);
        for (int i = 0; i < 16; i++) tick("atk_pull", 0, 0, 1, 0, 0, 5, 527);
        tick("atk_done", 0, 0, 1, 0, 0, 0, 527);
        tick("atk_held_no_retrig", 0, 0, 1, 0, 0, 0, 527);
        tick("atk_released", 0, 0, 0, 0, 0, 0, 527);

        tick("dir_start", 0, 0, 1, 1, 0, 6, 527);
        for (int i = 0; i < 3; i++) tick("dir_start", 0, 0, 0, 0, 0, 6, 527);
        for (int i = 0; i < 2; i++) tick("dir_end", 0, 0, 0, 0, 0, 7, 527);
        hit_pulse();
        for (int i = 1; i <= 15; i++) tick("stun", 0, 0, 0, 0, i == 4, 9, 519);
        tick("stun_exit", 0, 0, 0, 0, 0, 0, 519);

        tick("walkback", 0, 1, 0, 0, 0, 2, 517);
        tick("block_enter", 0, 1, 0, 0, 1, 10, 517);
        for (int i = 2; i <= 5; i++) tick("block", 0, 1, 0, 0, 0, 10, 517);
        tick("block_rehit", 0, 1, 0, 0, 1, 10, 517);
        for (int i = 0; i < 9; i++) tick("block_restarted", 0, 1, 0, 0, 0, 10, 517);
        tick("block_exit", 0, 1, 0, 0, 0, 0, 517);
        tick("walkback2", 0, 1, 0, 0, 0, 2, 515);

        p = 515;
        while (p > 0) begin
            p = (p > 2) ? p - 2 : 0;
            tick("walkback_run", 0, 1, 0, 0, 0, 2, p);
        end
        tick("min_clamp", 0, 1, 0, 0, 0, 2, 0);
        tick("idle_at_min", 0, 0, 0, 0, 0, 0, 0);
        tick("kb_clamp", 0, 0, 0, 0, 1, 9, 0);
        for (int i = 0; i < 14; i++) tick("stun2", 0, 0, 0, 0, 0, 9, 0);
        tick("stun2_exit", 0, 0, 0, 0, 0, 0, 0);

        tick("atk2_start", 0, 0, 1, 0, 0, 3, 0);
        for (int i = 0; i < 4; i++) tick("atk2_start", 0, 0, 0, 0, 0, 3, 0);
        for (int i = 0; i < 2; i++) tick("atk2_end", 0, 0, 0, 0, 0, 4, 0);
        for (int i = 0; i < 3; i++) tick("atk2_pull", 0, 0, 0, 0, 0, 5, 0);
        hit_pulse();
        reset_tick();
        tick("post_reset", 0, 0, 0, 0, 0, 0, 100);

        repeat (4) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: %0d expectations left, required 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
